regfile_mp: RTL

Parametrised multi-read-port register file with hardwired-zero entry 0, a self-clearing reset sequencer and a per-register pending-write scoreboard. It sits in the decode stage of the RISC-V core and replaces the fixed 32x32, two-read-port register file. Read ports are combinational. Writes, clearing and scoreboard updates are synchronous to `clk`.

---
 rtl/regfile_mp.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired-zero x0, self-clearing reset sequencer
// and per-register pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  mark_valid,
  input  logic [AW-1:0]         mark_addr,
  output logic                  ready
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cidx_q, cidx_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic            mem_wen;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    cidx_d    = cidx_q;
    busy_d    = busy_q;
    mem_wen   = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    case (state_q)
      CLEAR: begin
        mem_wen   = 1'b1;
        mem_waddr = cidx_q;
        mem_wdata = '0;
        cidx_d    = cidx_q + AW'(1);
        if (cidx_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (we && (waddr != '0)) begin
          mem_wen        = 1'b1;
          busy_d[waddr]  = 1'b0;
        end
        // Applied after the write clear so a same-edge mark (newer producer) wins.
        if (mark_valid && (mark_addr != '0)) busy_d[mark_addr] = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
    if (rst) mem_wen = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cidx_q  <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cidx_q  <= cidx_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is never reset; only the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (mem_wen) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready = (state_q == RUN);

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] stored;
    logic            stored_busy;

    assign ra          = raddr[i*AW +: AW];
    assign stored      = (ready && (ra != '0)) ? mem_q[ra] : '0;
    assign stored_busy = ready && (ra != '0) && busy_q[ra];

`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit                  = ready && we && (waddr != '0) && (ra == waddr);
    assign rdata[i*XLEN +: XLEN] = hit ? wdata : stored;
    assign rbusy[i]             = hit ? (mark_valid && (mark_addr == waddr)) : stored_busy;
`else
    assign rdata[i*XLEN +: XLEN] = stored;
    assign rbusy[i]             = stored_busy;
`endif
  end

endmodule
